video_timing_scheduler: RTL and testbench

//  Configures and sequences the pong video timer (hsync/vsync line and frame counters).

---
 rtl/video_timing_scheduler_pkg.sv | 29 ++
 rtl/video_timing_scheduler_if.sv | 31 +++
 rtl/video_timing_scheduler_shadow_regs.sv | 37 +++
 rtl/video_timing_scheduler.sv | 71 +++++++
 tb/tb_video_timing_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_scheduler_pkg.sv
// video_timing_scheduler_pkg: shared widths, FSM states, config address codes and 640x480 defaults
package video_timing_scheduler_pkg;
  localparam int XRES = 10;
  localparam int YRES = 10;
  localparam int RESTART_CYC = 2;
  typedef enum logic [1:0] {HOLD, RUN, PEND} state_t;
  localparam logic [2:0] CFG_H_SP = 3'd0;
  localparam logic [2:0] CFG_H_FP = 3'd1;
  localparam logic [2:0] CFG_H_AV = 3'd2;
  localparam logic [2:0] CFG_H_BP = 3'd3;
  localparam logic [2:0] CFG_V_SP = 3'd4;
  localparam logic [2:0] CFG_V_FP = 3'd5;
  localparam logic [2:0] CFG_V_AV = 3'd6;
  localparam logic [2:0] CFG_V_BP = 3'd7;
  typedef struct packed {
    logic [XRES-1:0] h_sp;
    logic [XRES-1:0] h_fp;
    logic [XRES-1:0] h_av;
    logic [XRES-1:0] h_bp;
    logic [YRES-1:0] v_sp;
    logic [YRES-1:0] v_fp;
    logic [YRES-1:0] v_av;
    logic [YRES-1:0] v_bp;
  } timing_t;
  localparam timing_t DEFAULT_TIMING = '{
    h_sp: XRES'(96), h_fp: XRES'(16), h_av: XRES'(640), h_bp: XRES'(48),
    v_sp: YRES'(2), v_fp: YRES'(10), v_av: YRES'(480), v_bp: YRES'(33)
  };
endpackage

// File: rtl/video_timing_scheduler_if.sv
// video_timing_scheduler_if: timer strobes, config bus, update handshake and active timing outputs
//   slave  = scheduler side (takes strobes/config/ack, drives timing/status)
//   master = controller/timer side
interface video_timing_scheduler_if;
  import video_timing_scheduler_pkg::*;
  logic            line_end;
  logic            frame_end;
  logic [YRES-1:0] yposition;
  logic            cfg_wr;
  logic [2:0]      cfg_addr;
  logic [XRES-1:0] cfg_data;
  logic            cfg_commit;
  logic            update_ack;
  logic [XRES-1:0] h_sp, h_fp, h_av, h_bp;
  logic [YRES-1:0] v_sp, v_fp, v_av, v_bp;
  logic            timer_restart;
  logic            commit_pending;
  logic            cfg_err;
  logic            update_req;
  logic [7:0]      overrun_count;
  modport slave (
    input  line_end, frame_end, yposition, cfg_wr, cfg_addr, cfg_data, cfg_commit, update_ack,
    output h_sp, h_fp, h_av, h_bp, v_sp, v_fp, v_av, v_bp,
    output timer_restart, commit_pending, cfg_err, update_req, overrun_count
  );
  modport master (
    output line_end, frame_end, yposition, cfg_wr, cfg_addr, cfg_data, cfg_commit, update_ack,
    input  h_sp, h_fp, h_av, h_bp, v_sp, v_fp, v_av, v_bp,
    input  timer_restart, commit_pending, cfg_err, update_req, overrun_count
  );
endinterface

// File: rtl/video_timing_scheduler_shadow_regs.sv
// video_timing_scheduler_shadow_regs: 8 shadow timing registers with write decode and overflow check
//   clk, rst_n : clock, async active-low reset (restores 640x480 defaults)
//   wr/addr/data : single-cycle shadow write
//   shadow : current shadow timing
//   ovf    : H or V total does not fit its field width
module video_timing_scheduler_shadow_regs
  import video_timing_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  logic [2:0]      addr,
  input  logic [XRES-1:0] data,
  output timing_t         shadow,
  output logic            ovf
);
  logic [YRES-1:0] vdata;
  logic [XRES+1:0] h_sum;
  logic [YRES+1:0] v_sum;
  assign vdata = YRES'(data);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow <= DEFAULT_TIMING;
    else if (wr) begin
      shadow.h_sp <= addr == CFG_H_SP ? data : shadow.h_sp;
      shadow.h_fp <= addr == CFG_H_FP ? data : shadow.h_fp;
      shadow.h_av <= addr == CFG_H_AV ? data : shadow.h_av;
      shadow.h_bp <= addr == CFG_H_BP ? data : shadow.h_bp;
      shadow.v_sp <= addr == CFG_V_SP ? vdata : shadow.v_sp;
      shadow.v_fp <= addr == CFG_V_FP ? vdata : shadow.v_fp;
      shadow.v_av <= addr == CFG_V_AV ? vdata : shadow.v_av;
      shadow.v_bp <= addr == CFG_V_BP ? vdata : shadow.v_bp;
    end
  // Sums carry two guard bits; any set guard bit means the total overflows the field
  assign h_sum = (XRES+2)'(shadow.h_sp) + (XRES+2)'(shadow.h_fp) + (XRES+2)'(shadow.h_av) + (XRES+2)'(shadow.h_bp);
  assign v_sum = (YRES+2)'(shadow.v_sp) + (YRES+2)'(shadow.v_fp) + (YRES+2)'(shadow.v_av) + (YRES+2)'(shadow.v_bp);
  assign ovf = |h_sum[XRES+1:XRES] || |v_sum[YRES+1:YRES];
endmodule

// File: rtl/video_timing_scheduler.sv
// video_timing_scheduler: active/shadow video timing with frame-boundary switch and per-frame update request
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : slave modport carrying timer strobes, config bus, update handshake and timing outputs
module video_timing_scheduler
  import video_timing_scheduler_pkg::*;
(
  input logic                        clk,
  input logic                        rst_n,
  video_timing_scheduler_if.slave    bus
);
  localparam int CNT_W = $clog2(RESTART_CYC + 1);
  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  timing_t          active;
  timing_t          shadow;
  logic             ovf;
  video_timing_scheduler_shadow_regs u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (bus.cfg_wr),
    .addr   (bus.cfg_addr),
    .data   (bus.cfg_data),
    .shadow (shadow),
    .ovf    (ovf)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state              <= HOLD;
      hold_cnt           <= '0;
      active             <= DEFAULT_TIMING;
      bus.timer_restart  <= 1'b1;
      bus.commit_pending <= 1'b0;
      bus.cfg_err        <= 1'b0;
      bus.update_req     <= 1'b0;
      bus.overrun_count  <= '0;
    end else if (state == HOLD) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
      if (hold_cnt == CNT_W'(RESTART_CYC - 1)) begin
        state             <= RUN;
        bus.timer_restart <= 1'b0;
      end
    end else if (state == PEND && bus.frame_end) begin
      // Shadow is sampled before any same-edge write lands, so active gets the old value
      active             <= shadow;
      bus.commit_pending <= 1'b0;
      state              <= HOLD;
      hold_cnt           <= '0;
      bus.timer_restart  <= 1'b1;
      bus.update_req     <= 1'b0;
    end else begin
      if (state == RUN && bus.cfg_commit) begin
        bus.cfg_err <= ovf;
        if (!ovf) begin
          bus.commit_pending <= 1'b1;
          state              <= PEND;
        end
      end
      if (bus.update_req) begin
        if (bus.update_ack || bus.frame_end) bus.update_req <= 1'b0;
        if (!bus.update_ack && bus.frame_end) bus.overrun_count <= bus.overrun_count + {7'd0, ~&bus.overrun_count};
      end else if (bus.line_end && bus.yposition == active.v_av - YRES'(1)) bus.update_req <= 1'b1;
    end
  assign bus.h_sp = active.h_sp;
  assign bus.h_fp = active.h_fp;
  assign bus.h_av = active.h_av;
  assign bus.h_bp = active.h_bp;
  assign bus.v_sp = active.v_sp;
  assign bus.v_fp = active.v_fp;
  assign bus.v_av = active.v_av;
  assign bus.v_bp = active.v_bp;
endmodule

// File: tb/tb_video_timing_scheduler.sv
// tb_video_timing_scheduler: directed + randomized checks against a behavioural scheduler model
module tb_video_timing_scheduler;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  video_timing_scheduler_if bus ();
  video_timing_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int act[8];
  int sh[8];
  int restart_left;
  bit pend, err, req;
  int ovr;
  function automatic void model_reset();
    act = '{96, 16, 640, 48, 2, 10, 480, 33};
    sh = act;
    restart_left = 2;
    pend = 0;
    err = 0;
    req = 0;
    ovr = 0;
  endfunction
  function automatic void step();
    int old_sh[8];
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_sh = sh;
    if (bus.cfg_wr) sh[bus.cfg_addr] = int'(bus.cfg_data);
    if (restart_left > 0) restart_left--;
    else if (pend && bus.frame_end) begin
      act = old_sh;
      pend = 0;
      restart_left = 2;
      req = 0;
    end else begin
      if (!pend && bus.cfg_commit) begin
        if (old_sh[0] + old_sh[1] + old_sh[2] + old_sh[3] > 1023 ||
            old_sh[4] + old_sh[5] + old_sh[6] + old_sh[7] > 1023) err = 1;
        else begin
          err = 0;
          pend = 1;
        end
      end
      if (req) begin
        if (bus.update_ack) req = 0;
        else if (bus.frame_end) begin
          req = 0;
          if (ovr < 255) ovr++;
        end
      end else if (bus.line_end && int'(bus.yposition) == (act[6] + 1023) % 1024) req = 1;
    end
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int dut_field(int i);
    case (i)
      0: return int'(bus.h_sp);
      1: return int'(bus.h_fp);
      2: return int'(bus.h_av);
      3: return int'(bus.h_bp);
      4: return int'(bus.v_sp);
      5: return int'(bus.v_fp);
      6: return int'(bus.v_av);
      default: return int'(bus.v_bp);
    endcase
  endfunction
  task automatic check_all();
    string names[8] = '{"h_sp", "h_fp", "h_av", "h_bp", "v_sp", "v_fp", "v_av", "v_bp"};
    for (int i = 0; i < 8; i++) check(names[i], dut_field(i), act[i]);
    check("timer_restart", int'(bus.timer_restart), int'(restart_left > 0));
    check("commit_pending", int'(bus.commit_pending), int'(pend));
    check("cfg_err", int'(bus.cfg_err), int'(err));
    check("update_req", int'(bus.update_req), int'(req));
    check("overrun_count", int'(bus.overrun_count), ovr);
  endtask
  task automatic tick();
    @(posedge clk);
    step();
    #1;
    check_all();
    bus.line_end = 0;
    bus.frame_end = 0;
    bus.cfg_wr = 0;
    bus.cfg_commit = 0;
    bus.update_ack = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    tick();
    rst_n = 1;
  endtask
  task automatic write(input int addr, input int data);
    bus.cfg_wr = 1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = 10'(data);
    tick();
  endtask
  initial begin
    rst_n = 0;
    bus.line_end = 0;
    bus.frame_end = 0;
    bus.yposition = '0;
    bus.cfg_wr = 0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.cfg_commit = 0;
    bus.update_ack = 0;
    model_reset();
    tick();
    tick();
    check("rst_h_av", int'(bus.h_av), 640);
    check("rst_v_bp", int'(bus.v_bp), 33);
    rst_n = 1;
    tick();
    check("restart_c1", int'(bus.timer_restart), 1);
    tick();
    check("restart_c2", int'(bus.timer_restart), 0);
    // legal H active change, switched at frame end
    write(2, 800);
    bus.cfg_commit = 1;
    tick();
    check("pend_set", int'(bus.commit_pending), 1);
    repeat (3) tick();
    check("h_av_held", int'(bus.h_av), 640);
    bus.frame_end = 1;
    tick();
    check("h_av_switched", int'(bus.h_av), 800);
    check("restart_sw1", int'(bus.timer_restart), 1);
    tick();
    check("restart_sw2", int'(bus.timer_restart), 1);
    tick();
    check("restart_sw3", int'(bus.timer_restart), 0);
    // overflowing commit rejected, then a valid one clears the error
    write(2, 1000);
    bus.cfg_commit = 1;
    tick();
    check("ovf_err", int'(bus.cfg_err), 1);
    check("ovf_no_pend", int'(bus.commit_pending), 0);
    write(2, 600);
    bus.cfg_commit = 1;
    tick();
    check("err_cleared", int'(bus.cfg_err), 0);
    bus.frame_end = 1;
    tick();
    check("h_av_600", int'(bus.h_av), 600);
    repeat (3) tick();
    // update handshake
    bus.line_end = 1;
    bus.yposition = 10'd479;
    tick();
    check("req_set", int'(bus.update_req), 1);
    repeat (2) tick();
    bus.update_ack = 1;
    tick();
    check("req_acked", int'(bus.update_req), 0);
    check("ovr_zero", int'(bus.overrun_count), 0);
    bus.line_end = 1;
    tick();
    bus.update_ack = 1;
    bus.frame_end = 1;
    tick();
    check("ack_fe_no_ovr", int'(bus.overrun_count), 0);
    for (int f = 0; f < 260; f++) begin
      bus.line_end = 1;
      tick();
      bus.frame_end = 1;
      tick();
    end
    check("ovr_sat", int'(bus.overrun_count), 255);
    // reset while a commit is pending discards shadow writes
    write(0, 50);
    bus.cfg_commit = 1;
    tick();
    check("pend_before_rst", int'(bus.commit_pending), 1);
    do_reset();
    check("rst_pend_clr", int'(bus.commit_pending), 0);
    check("rst_ovr_clr", int'(bus.overrun_count), 0);
    repeat (2) tick();
    bus.cfg_commit = 1;
    tick();
    bus.frame_end = 1;
    tick();
    check("shadow_lost", int'(bus.h_sp), 96);
    repeat (2) tick();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else begin
        bus.cfg_wr = ($urandom % 8) == 0;
        bus.cfg_addr = 3'($urandom % 8);
        bus.cfg_data = 10'($urandom_range(0, 350));
        bus.cfg_commit = ($urandom % 16) == 0;
        bus.frame_end = ($urandom % 24) == 0;
        bus.line_end = ($urandom % 4) == 0;
        bus.yposition = ($urandom % 2) == 0 ? 10'((act[6] + 1023) % 1024) : 10'($urandom);
        bus.update_ack = ($urandom % 6) == 0;
        tick();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
